// File: rtl/uart_lite_param.sv
// Wishbone-attached lite UART: TX/RX FIFOs, 16x oversampled 8N1-style framing,
// sticky error status and a registered level interrupt.
module uart_lite_param #(
  parameter int          DATA_BITS  = 8,
  parameter int          FIFO_DEPTH = 16,
  parameter logic [15:0] DIV_RESET  = 16'd27
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic [3:0]  wb_adr_i,
  input  logic [31:0] wb_dat_i,
  output logic [31:0] wb_dat_o,
  input  logic [3:0]  wb_sel_i,
  input  logic        wb_we_i,
  input  logic        wb_stb_i,
  input  logic        wb_cyc_i,
  output logic        wb_ack_o,
  output logic        int_o,
  output logic        stx_pad_o,
  input  logic        srx_pad_i
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

  // bus
  logic        r_ack;
  logic [31:0] r_dat_o;
  logic        r_rd_pop;
  logic [1:0]  w_reg_sel;
  logic        w_req;
  logic        w_acc;
  logic        w_wr;
  logic        w_wr_data;
  logic        w_wr_stat;
  logic        w_wr_div;
  logic        w_wr_ctrl;
  logic [31:0] w_status;
  logic        w_unused;

  // configuration and status
  logic [15:0] r_div;
  logic [2:0]  r_ctrl;
  logic        r_rx_ovr;
  logic        r_frame_err;
  logic        r_tx_ovf;
  logic        r_int;

  // baud generator
  logic [15:0] r_baud_cnt;
  logic        w_tick;

  // TX FIFO and shifter
  logic [DATA_BITS-1:0] r_tx_mem [FIFO_DEPTH];
  logic [AW-1:0]        r_tx_wr_ptr;
  logic [AW-1:0]        r_tx_rd_ptr;
  logic [CW-1:0]        r_tx_count;
  logic                 w_tx_full;
  logic                 w_tx_empty;
  logic                 w_tx_pop;
  logic                 w_tx_push;
  logic                 w_tx_ovf_set;
  logic                 w_tx_idle;
  logic [1:0]           r_tx_state;
  logic [3:0]           r_tx_tcnt;
  logic [2:0]           r_tx_bcnt;
  logic [DATA_BITS-1:0] r_tx_shift;
  logic                 r_tx_bit;

  // RX front end, FSM and FIFO
  logic [1:0]           r_rx_sync;
  logic                 r_rx_prev;
  logic                 w_rx_in;
  logic [1:0]           r_rx_state;
  logic [3:0]           r_rx_tcnt;
  logic [2:0]           r_rx_bcnt;
  logic [DATA_BITS-1:0] r_rx_shift;
  logic                 r_rx_brk;
  logic                 w_rx_stop_smp;
  logic                 w_rx_done;
  logic                 w_rx_ferr;
  logic [DATA_BITS-1:0] r_rx_mem [FIFO_DEPTH];
  logic [AW-1:0]        r_rx_wr_ptr;
  logic [AW-1:0]        r_rx_rd_ptr;
  logic [CW-1:0]        r_rx_count;
  logic                 w_rx_full;
  logic                 w_rx_empty;
  logic                 w_rx_pop;
  logic                 w_rx_push;
  logic                 w_rx_ovr_set;
  logic [7:0]           w_rx_count8;

  // ---------------------------------------------------------------- bus decode
  assign w_reg_sel = wb_adr_i[3:2];
  assign w_req     = wb_stb_i & wb_cyc_i & ~r_ack;
  assign w_acc     = r_ack & wb_stb_i & wb_cyc_i;
  assign w_wr      = w_acc & wb_we_i & wb_sel_i[0];
  assign w_wr_data = w_wr & (w_reg_sel == 2'd0);
  assign w_wr_stat = w_wr & (w_reg_sel == 2'd1);
  assign w_wr_div  = w_wr & (w_reg_sel == 2'd2);
  assign w_wr_ctrl = w_wr & (w_reg_sel == 2'd3);
  assign w_unused  = ^{wb_adr_i[1:0], wb_sel_i[3:1], wb_dat_i[31:16]};

  generate
    if (CW > 8) begin : g_cnt_sat
      assign w_rx_count8 = (r_rx_count[CW-1:8] != '0) ? 8'hFF : r_rx_count[7:0];
    end else begin : g_cnt_ext
      assign w_rx_count8 = 8'(r_rx_count);
    end
  endgenerate

  assign w_status = {8'h00, w_rx_count8, 10'h000, r_tx_ovf, r_frame_err, r_rx_ovr,
                     w_tx_idle, w_tx_full, ~w_rx_empty};

  // Read data is captured in the request cycle so it is stable during ack; the
  // RX pop is decided at the same moment so an empty read never moves pointers.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_ack    <= 1'b0;
      r_dat_o  <= '0;
      r_rd_pop <= 1'b0;
    end else begin
      r_ack    <= w_req;
      r_rd_pop <= w_req & ~wb_we_i & (w_reg_sel == 2'd0) & ~w_rx_empty;
      r_dat_o  <= '0;
      if (w_req & ~wb_we_i) begin
        case (w_reg_sel)
          2'd0:    if (!w_rx_empty) r_dat_o <= 32'(r_rx_mem[r_rx_rd_ptr]);
          2'd1:    r_dat_o <= w_status;
          2'd2:    r_dat_o <= {16'h0000, r_div};
          default: r_dat_o <= {29'h0, r_ctrl};
        endcase
      end
    end
  end

  // ------------------------------------------------- config, sticky bits, irq
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_div       <= DIV_RESET;
      r_ctrl      <= '0;
      r_rx_ovr    <= 1'b0;
      r_frame_err <= 1'b0;
      r_tx_ovf    <= 1'b0;
      r_int       <= 1'b0;
    end else begin
      if (w_wr_div)  r_div  <= wb_dat_i[15:0];
      if (w_wr_ctrl) r_ctrl <= wb_dat_i[2:0];
      r_rx_ovr    <= w_rx_ovr_set | (r_rx_ovr    & ~(w_wr_stat & wb_dat_i[3]));
      r_frame_err <= w_rx_ferr    | (r_frame_err & ~(w_wr_stat & wb_dat_i[4]));
      r_tx_ovf    <= w_tx_ovf_set | (r_tx_ovf    & ~(w_wr_stat & wb_dat_i[5]));
      r_int       <= (r_ctrl[0] & ~w_rx_empty) | (r_ctrl[1] & w_tx_idle);
    end
  end

  // ------------------------------------------------------------ baud ticks
  assign w_tick = (r_baud_cnt == 16'd0);

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_baud_cnt <= 16'd0;
    end else if (w_tick) begin
      r_baud_cnt <= (r_div == 16'd0) ? 16'd0 : r_div - 16'd1;
    end else begin
      r_baud_cnt <= r_baud_cnt - 16'd1;
    end
  end

  // ------------------------------------------------------------ TX FIFO
  assign w_tx_full    = (r_tx_count == CW'(FIFO_DEPTH));
  assign w_tx_empty   = (r_tx_count == '0);
  assign w_tx_pop     = (r_tx_state == S_IDLE) & ~w_tx_empty;
  assign w_tx_push    = w_wr_data & (~w_tx_full | w_tx_pop);
  assign w_tx_ovf_set = w_wr_data & w_tx_full & ~w_tx_pop;
  assign w_tx_idle    = w_tx_empty & (r_tx_state == S_IDLE);

  always_ff @(posedge wb_clk_i) begin
    if (w_tx_push) r_tx_mem[r_tx_wr_ptr] <= wb_dat_i[DATA_BITS-1:0];
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_tx_wr_ptr <= '0;
      r_tx_rd_ptr <= '0;
      r_tx_count  <= '0;
    end else begin
      if (w_tx_push) r_tx_wr_ptr <= r_tx_wr_ptr + 1'b1;
      if (w_tx_pop)  r_tx_rd_ptr <= r_tx_rd_ptr + 1'b1;
      case ({w_tx_push, w_tx_pop})
        2'b10:   r_tx_count <= r_tx_count + 1'b1;
        2'b01:   r_tx_count <= r_tx_count - 1'b1;
        default: r_tx_count <= r_tx_count;
      endcase
    end
  end

  // ------------------------------------------------------------ TX FSM
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_tx_state <= S_IDLE;
      r_tx_tcnt  <= '0;
      r_tx_bcnt  <= '0;
      r_tx_shift <= '0;
      r_tx_bit   <= 1'b1;
    end else begin
      case (r_tx_state)
        S_IDLE: begin
          r_tx_bit <= 1'b1;
          if (w_tx_pop) begin
            r_tx_shift <= r_tx_mem[r_tx_rd_ptr];
            r_tx_tcnt  <= '0;
            r_tx_bit   <= 1'b0;
            r_tx_state <= S_START;
          end
        end
        S_START: if (w_tick) begin
          r_tx_tcnt <= r_tx_tcnt + 4'd1;
          if (r_tx_tcnt == 4'd15) begin
            r_tx_bcnt  <= '0;
            r_tx_bit   <= r_tx_shift[0];
            r_tx_state <= S_DATA;
          end
        end
        S_DATA: if (w_tick) begin
          r_tx_tcnt <= r_tx_tcnt + 4'd1;
          if (r_tx_tcnt == 4'd15) begin
            r_tx_shift <= r_tx_shift >> 1;
            if (r_tx_bcnt == LAST_BIT) begin
              r_tx_bit   <= 1'b1;
              r_tx_state <= S_STOP;
            end else begin
              r_tx_bcnt <= r_tx_bcnt + 3'd1;
              r_tx_bit  <= r_tx_shift[1];
            end
          end
        end
        default: if (w_tick) begin
          r_tx_tcnt <= r_tx_tcnt + 4'd1;
          if (r_tx_tcnt == 4'd15) r_tx_state <= S_IDLE;
        end
      endcase
    end
  end

  // ------------------------------------------------------------ RX front end
  assign w_rx_in = r_ctrl[2] ? r_tx_bit : r_rx_sync[1];

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_rx_sync <= 2'b11;
      r_rx_prev <= 1'b1;
    end else begin
      r_rx_sync <= {r_rx_sync[0], srx_pad_i};
      r_rx_prev <= w_rx_in;
    end
  end

  // ------------------------------------------------------------ RX FSM
  assign w_rx_stop_smp = (r_rx_state == S_STOP) & ~r_rx_brk & w_tick & (r_rx_tcnt == 4'd15);
  assign w_rx_done     = w_rx_stop_smp & w_rx_in;
  assign w_rx_ferr     = w_rx_stop_smp & ~w_rx_in;

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_rx_state <= S_IDLE;
      r_rx_tcnt  <= '0;
      r_rx_bcnt  <= '0;
      r_rx_shift <= '0;
      r_rx_brk   <= 1'b0;
    end else begin
      case (r_rx_state)
        S_IDLE: if (r_rx_prev & ~w_rx_in) begin
          r_rx_tcnt  <= '0;
          r_rx_state <= S_START;
        end
        S_START: if (w_tick) begin
          r_rx_tcnt <= r_rx_tcnt + 4'd1;
          if (r_rx_tcnt == 4'd7) begin
            r_rx_tcnt  <= '0;
            r_rx_bcnt  <= '0;
            r_rx_state <= w_rx_in ? S_IDLE : S_DATA;
          end
        end
        S_DATA: if (w_tick) begin
          r_rx_tcnt <= r_rx_tcnt + 4'd1;
          if (r_rx_tcnt == 4'd15) begin
            r_rx_shift <= {w_rx_in, r_rx_shift[DATA_BITS-1:1]};
            if (r_rx_bcnt == LAST_BIT) r_rx_state <= S_STOP;
            else                       r_rx_bcnt  <= r_rx_bcnt + 3'd1;
          end
        end
        default: begin
          // after a bad stop bit, hold here until the line returns high
          if (r_rx_brk) begin
            if (w_rx_in) begin
              r_rx_brk   <= 1'b0;
              r_rx_state <= S_IDLE;
            end
          end else if (w_tick) begin
            r_rx_tcnt <= r_rx_tcnt + 4'd1;
            if (r_rx_tcnt == 4'd15) begin
              if (w_rx_in) r_rx_state <= S_IDLE;
              else         r_rx_brk   <= 1'b1;
            end
          end
        end
      endcase
    end
  end

  // ------------------------------------------------------------ RX FIFO
  assign w_rx_full    = (r_rx_count == CW'(FIFO_DEPTH));
  assign w_rx_empty   = (r_rx_count == '0);
  assign w_rx_pop     = w_acc & r_rd_pop;
  assign w_rx_push    = w_rx_done & (~w_rx_full | w_rx_pop);
  assign w_rx_ovr_set = w_rx_done & w_rx_full & ~w_rx_pop;

  always_ff @(posedge wb_clk_i) begin
    if (w_rx_push) r_rx_mem[r_rx_wr_ptr] <= r_rx_shift;
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_rx_wr_ptr <= '0;
      r_rx_rd_ptr <= '0;
      r_rx_count  <= '0;
    end else begin
      if (w_rx_push) r_rx_wr_ptr <= r_rx_wr_ptr + 1'b1;
      if (w_rx_pop)  r_rx_rd_ptr <= r_rx_rd_ptr + 1'b1;
      case ({w_rx_push, w_rx_pop})
        2'b10:   r_rx_count <= r_rx_count + 1'b1;
        2'b01:   r_rx_count <= r_rx_count - 1'b1;
        default: r_rx_count <= r_rx_count;
      endcase
    end
  end

  // ------------------------------------------------------------ outputs
  assign wb_ack_o  = r_ack;
  assign wb_dat_o  = r_dat_o;
  assign int_o     = r_int;
  assign stx_pad_o = r_ctrl[2] | r_tx_bit;

endmodule

// File: tb/tb_uart_lite_param.sv
// Randomised bench for uart_lite_param: queue-based models of both FIFOs and
// a bit-level line decoder, plus directed framing, overflow, irq and reset checks.
module tb_uart_lite_param;

  localparam int DB    = 8;
  localparam int DEPTH = 4;
  localparam logic [3:0] A_DATA = 4'h0;
  localparam logic [3:0] A_STAT = 4'h4;
  localparam logic [3:0] A_DIV  = 4'h8;
  localparam logic [3:0] A_CTRL = 4'hC;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  wb_adr_i;
  logic [31:0] wb_dat_i;
  logic [31:0] wb_dat_o;
  logic [3:0]  wb_sel_i;
  logic        wb_we_i;
  logic        wb_stb_i;
  logic        wb_cyc_i;
  logic        wb_ack_o;
  logic        int_o;
  logic        stx_pad_o;
  logic        srx;

  int n_vec = 0;
  int n_err = 0;
  int g_div = 1;
  int g_lat;
  logic g_ack_tail;

  bit   dec_en  = 0;
  bit   edge_en = 0;
  int   n_edges = 0;
  int   stop_errs = 0;
  logic [7:0] dec_byte;
  logic [7:0] q_txd[$];

  always #5 clk = ~clk;

  uart_lite_param #(.DATA_BITS(DB), .FIFO_DEPTH(DEPTH), .DIV_RESET(16'd27)) dut (
    .wb_clk_i (clk),
    .wb_rst_i (rst),
    .wb_adr_i (wb_adr_i),
    .wb_dat_i (wb_dat_i),
    .wb_dat_o (wb_dat_o),
    .wb_sel_i (wb_sel_i),
    .wb_we_i  (wb_we_i),
    .wb_stb_i (wb_stb_i),
    .wb_cyc_i (wb_cyc_i),
    .wb_ack_o (wb_ack_o),
    .int_o    (int_o),
    .stx_pad_o(stx_pad_o),
    .srx_pad_i(srx)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic wb_xfer(input logic [3:0] adr, input logic we, input logic [31:0] wdat,
                         output logic [31:0] rdat);
    int t;
    @(negedge clk);
    wb_adr_i = adr; wb_we_i = we; wb_dat_i = wdat; wb_sel_i = 4'hF;
    wb_stb_i = 1'b1; wb_cyc_i = 1'b1;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!wb_ack_o && t < 8);
    if (!wb_ack_o) check_val("ack_timeout", 32'd0, 32'd1);
    rdat  = wb_dat_o;
    g_lat = t;
    @(negedge clk);
    g_ack_tail = wb_ack_o;
    wb_stb_i = 1'b0; wb_cyc_i = 1'b0; wb_we_i = 1'b0;
    $display("[%0t] wb %s adr=0x%0h dat=0x%08h", $time, we ? "WR" : "RD", adr, we ? wdat : rdat);
  endtask

  task automatic rd(input logic [3:0] adr, output logic [31:0] d);
    wb_xfer(adr, 1'b0, 32'h0, d);
  endtask

  task automatic wr(input logic [3:0] adr, input logic [31:0] v);
    logic [31:0] dummy;
    wb_xfer(adr, 1'b1, v, dummy);
  endtask

  task automatic send_rx(input logic [7:0] b, input logic stop, input int div);
    srx = 1'b0;
    repeat (16 * div) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      srx = b[i];
      repeat (16 * div) @(negedge clk);
    end
    srx = stop;
    repeat (16 * div) @(negedge clk);
    srx = 1'b1;
  endtask

  task automatic wait_tx_idle(input string tag);
    logic [31:0] s;
    s = 32'h0;
    for (int k = 0; k < 200; k++) begin
      rd(A_STAT, s);
      if (s[2]) break;
      repeat (50) @(negedge clk);
    end
    check_val(tag, 32'(s[2]), 32'd1);
  endtask

  // line decoder: mid-bit sampling at the bench's notion of the bit period
  always begin
    @(negedge stx_pad_o);
    if (dec_en) begin
      repeat (8 * g_div) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
        repeat (16 * g_div) @(negedge clk);
        dec_byte[i] = stx_pad_o;
      end
      repeat (16 * g_div) @(negedge clk);
      if (!stx_pad_o) stop_errs++;
      q_txd.push_back(dec_byte);
    end
  end

  always @(negedge stx_pad_o) if (edge_en) n_edges++;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    n_err++;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    logic [31:0] s, d, exp;
    logic [7:0]  b;
    logic [7:0]  one_edge [9];
    logic [7:0]  q_exp[$];
    logic        ovr;
    int          div, n;

    one_edge = '{8'h00, 8'h80, 8'hC0, 8'hE0, 8'hF0, 8'hF8, 8'hFC, 8'hFE, 8'hFF};
    rst = 1'b1; srx = 1'b1;
    wb_adr_i = '0; wb_dat_i = '0; wb_sel_i = '0; wb_we_i = 0; wb_stb_i = 0; wb_cyc_i = 0;

    // reset state
    repeat (3) @(negedge clk);
    check_val("rst_ack", 32'(wb_ack_o), 32'd0);
    check_val("rst_dat", wb_dat_o, 32'd0);
    check_val("rst_int", 32'(int_o), 32'd0);
    check_val("rst_stx", 32'(stx_pad_o), 32'd1);
    rst = 1'b0;
    rd(A_STAT, s); check_val("rst_status", s, 32'h4);
    check_val("ack_latency", g_lat, 32'd1);
    check_val("ack_one_cycle", 32'(g_ack_tail), 32'd0);
    rd(A_DIV, s);  check_val("rst_div", s, 32'd27);
    rd(A_CTRL, s); check_val("rst_ctrl", s, 32'd0);
    check_val("idle_dat", wb_dat_o, 32'd0);

    // loopback character
    wr(A_DIV, 1); repeat (40) @(negedge clk);
    wr(A_CTRL, 4); rd(A_CTRL, s); check_val("ctrl_rw", s, 32'h4);
    wr(A_DATA, 32'hFFFF_FFA5);
    repeat (50) @(negedge clk);
    check_val("lb_stx_high", 32'(stx_pad_o), 32'd1);
    repeat (150) @(negedge clk);
    rd(A_STAT, s); check_val("lb_status", s, 32'h0001_0005);
    rd(A_DATA, d); check_val("lb_data", d, 32'h0000_00A5);
    rd(A_DATA, d); check_val("empty_read", d, 32'h0);
    rd(A_STAT, s); check_val("empty_status", s, 32'h4);
    wr(A_CTRL, 0);

    // random TX characters decoded off the line
    for (int r = 0; r < 3; r++) begin
      div = $urandom_range(1, 3); g_div = div;
      wr(A_DIV, div); repeat (120) @(negedge clk);
      q_txd.delete(); q_exp.delete(); stop_errs = 0; dec_en = 1;
      n = $urandom_range(1, DEPTH + 1);
      for (int k = 0; k < n; k++) begin
        b = 8'($urandom);
        q_exp.push_back(b);
        wr(A_DATA, {24'h0, b});
      end
      wait_tx_idle("tx_idle_wait");
      repeat (10) @(negedge clk);
      dec_en = 0;
      check_val("tx_count", q_txd.size(), q_exp.size());
      while (q_exp.size() > 0 && q_txd.size() > 0)
        check_val("tx_byte", {24'h0, q_txd.pop_front()}, {24'h0, q_exp.pop_front()});
      check_val("tx_stop", stop_errs, 0);
      rd(A_STAT, s); check_val("tx_no_ovf", 32'(s[5]), 32'd0);
    end

    // TX overflow: DEPTH+2 pushes, one taken by the shifter, one dropped
    wr(A_DIV, 100); repeat (220) @(negedge clk);
    n_edges = 0; edge_en = 1;
    for (int k = 0; k < DEPTH + 2; k++) wr(A_DATA, {24'h0, one_edge[$urandom_range(0, 8)]});
    rd(A_STAT, s); check_val("tx_ovf_full", s & 32'h22, 32'h22);
    wr(A_DIV, 1);
    wait_tx_idle("ovf_idle_wait");
    repeat (20) @(negedge clk);
    edge_en = 0;
    check_val("tx_char_count", n_edges, DEPTH + 1);
    wr(A_STAT, 32'h20); rd(A_STAT, s); check_val("tx_ovf_clear", s, 32'h4);

    // glitch and framing error
    div = 2; wr(A_DIV, div); repeat (120) @(negedge clk);
    srx = 1'b0; repeat (4 * div) @(negedge clk); srx = 1'b1;
    repeat (400) @(negedge clk);
    rd(A_STAT, s); check_val("glitch_status", s, 32'h4);
    send_rx(8'($urandom), 1'b0, div);
    repeat (100) @(negedge clk);
    rd(A_STAT, s); check_val("ferr_status", s, 32'h14);
    wr(A_STAT, 32'h10); rd(A_STAT, s); check_val("ferr_clear", s, 32'h4);

    // RX characters against a FIFO model (first round overruns by exactly one)
    for (int r = 0; r < 3; r++) begin
      div = (r == 0) ? 2 : $urandom_range(1, 3);
      n   = (r == 0) ? DEPTH + 1 : $urandom_range(1, DEPTH + 2);
      wr(A_DIV, div); repeat (120) @(negedge clk);
      q_exp.delete(); ovr = 1'b0;
      for (int k = 0; k < n; k++) begin
        b = 8'($urandom);
        send_rx(b, 1'b1, div);
        if (q_exp.size() < DEPTH) q_exp.push_back(b);
        else ovr = 1'b1;
        repeat ($urandom_range(0, 20)) @(negedge clk);
      end
      exp = (32'(q_exp.size()) << 16) | (32'(ovr) << 3) | 32'h4 | 32'(q_exp.size() != 0);
      rd(A_STAT, s); check_val("rx_status", s, exp);
      for (int k = 0; k < DEPTH + 1; k++) begin
        exp = (q_exp.size() > 0) ? {24'h0, q_exp.pop_front()} : 32'h0;
        rd(A_DATA, d); check_val("rx_data", d, exp);
      end
      if (ovr) wr(A_STAT, 32'h08);
      rd(A_STAT, s); check_val("rx_clear", s, 32'h4);
    end

    // interrupts
    div = 2; wr(A_DIV, div); repeat (120) @(negedge clk);
    wr(A_CTRL, 1); repeat (3) @(negedge clk);
    check_val("int_empty", 32'(int_o), 32'd0);
    b = 8'($urandom);
    send_rx(b, 1'b1, div);
    repeat (5) @(negedge clk);
    check_val("int_rx", 32'(int_o), 32'd1);
    rd(A_DATA, d); check_val("int_data", d, {24'h0, b});
    check_val("int_hold", 32'(int_o), 32'd1);
    @(negedge clk);
    check_val("int_clear", 32'(int_o), 32'd0);
    wr(A_CTRL, 2); repeat (3) @(negedge clk);
    check_val("int_txidle", 32'(int_o), 32'd1);
    wr(A_CTRL, 0); repeat (3) @(negedge clk);
    check_val("int_off", 32'(int_o), 32'd0);

    // asynchronous reset in the middle of a character
    wr(A_DATA, 32'h00);
    for (int k = 0; k < 200 && stx_pad_o; k++) @(negedge clk);
    check_val("tx_start_seen", 32'(stx_pad_o), 32'd0);
    repeat (40) @(negedge clk);
    n_edges = 0; edge_en = 1;
    #2 rst = 1'b1;
    #1 check_val("rst_stx_async", 32'(stx_pad_o), 32'd1);
    check_val("rst_int_async", 32'(int_o), 32'd0);
    check_val("rst_ack_async", 32'(wb_ack_o), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (400) @(negedge clk);
    edge_en = 0;
    check_val("no_partial_char", n_edges, 0);
    check_val("post_rst_stx", 32'(stx_pad_o), 32'd1);
    rd(A_DIV, s);  check_val("post_rst_div", s, 32'd27);
    rd(A_STAT, s); check_val("post_rst_status", s, 32'h4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
